rfaludm_sequencer: RTL and testbench

RFALUDM_SEQUENCER -- requirements
Module: rfaludm_sequencer

---
 rtl/rfaludm_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_rfaludm_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfaludm_sequencer.sv
// Multi-cycle LEGv8 control sequencer for the register-file / ALU / data-memory datapath.
// Define RFALUDM_XZR_EN to treat register 31 as XZR, so write-back to it is dropped.
module rfaludm_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        Zero,
    output logic [5:0]  Read1,
    output logic [5:0]  Read2,
    output logic [5:0]  WriteReg,
    output logic        RegWrite,
    output logic [1:0]  ALUOp,
    output logic [10:0] OpCodefield,
    output logic [1:0]  AluSrc,
    output logic [8:0]  SEin,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        busy,
    output logic        done,
    output logic        branch_taken,
    output logic        illegal
);

    typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, BR} state_t;
    typedef enum logic [2:0] {CLS_R, CLS_LD, CLS_ST, CLS_CBZ, CLS_ILL} cls_t;

    state_t      state_reg, state_next;
    logic [31:0] instr_reg, cur_instr;
    logic        accept;
    cls_t        cls;
    logic        unused_bits;

    logic        ready_next, busy_next, regwrite_next, memread_next, memwrite_next;
    logic        done_next, taken_next, illegal_next;
    logic [5:0]  read1_next, read2_next, writereg_next;
    logic [1:0]  aluop_next, alusrc_next;
    logic [10:0] opcode_next;
    logic [8:0]  sein_next;

    assign accept      = (state_reg == IDLE) && instr_valid;
    // Outputs are computed from the state being entered, so the word being accepted is decoded directly.
    assign cur_instr   = accept ? instr : instr_reg;
    assign unused_bits = ^cur_instr[11:10];

    always_comb begin
        cls = CLS_ILL;
        if (cur_instr[31:24] == 8'b10110100) begin
            cls = CLS_CBZ;
        end else begin
            case (cur_instr[31:21])
                11'b10001011000, 11'b11001011000,
                11'b10001010000, 11'b10101010000: cls = CLS_R;
                11'b11111000010:                  cls = CLS_LD;
                11'b11111000000:                  cls = CLS_ST;
                default:                          cls = CLS_ILL;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (instr_valid) state_next = DECODE;
            DECODE: state_next = (cls == CLS_ILL) ? IDLE : EXEC;
            EXEC: begin
                case (cls)
                    CLS_R:          state_next = WB;
                    CLS_LD, CLS_ST: state_next = MEM;
                    CLS_CBZ:        state_next = BR;
                    default:        state_next = IDLE;
                endcase
            end
            MEM:     state_next = (cls == CLS_LD) ? WB : IDLE;
            WB, BR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_next    = (state_next == IDLE);
        busy_next     = (state_next != IDLE);
        read1_next    = '0;
        read2_next    = '0;
        writereg_next = '0;
        regwrite_next = 1'b0;
        aluop_next    = '0;
        alusrc_next   = '0;
        sein_next     = '0;
        opcode_next   = '0;

        if (state_next != IDLE) begin
            opcode_next = cur_instr[31:21];
            case (cls)
                CLS_R: begin
                    read1_next = {1'b0, cur_instr[9:5]};
                    read2_next = {1'b0, cur_instr[20:16]};
                end
                CLS_LD, CLS_ST: begin
                    read1_next = {1'b0, cur_instr[9:5]};
                    read2_next = {1'b0, cur_instr[4:0]};
                end
                CLS_CBZ: read2_next = {1'b0, cur_instr[4:0]};
                default: ;
            endcase
        end

        // ALU controls stay stable from EXEC until the instruction retires.
        if (state_next inside {EXEC, MEM, WB, BR}) begin
            case (cls)
                CLS_R: aluop_next = 2'b10;
                CLS_LD, CLS_ST: begin
                    aluop_next  = 2'b00;
                    alusrc_next = 2'b01;
                    sein_next   = cur_instr[20:12];
                end
                CLS_CBZ: aluop_next = 2'b01;
                default: ;
            endcase
        end

        if (state_next == WB) begin
            writereg_next = {1'b0, cur_instr[4:0]};
            regwrite_next = 1'b1;
`ifdef RFALUDM_XZR_EN
            if (cur_instr[4:0] == 5'd31) regwrite_next = 1'b0;
`else
            regwrite_next = 1'b1;
`endif
        end

        illegal_next  = (state_next == DECODE) && (cls == CLS_ILL);
        memread_next  = (state_next == MEM) && (cls == CLS_LD);
        memwrite_next = (state_next == MEM) && (cls == CLS_ST);
        done_next     = (state_next == WB) || (state_next == BR) ||
                        ((state_next == MEM) && (cls == CLS_ST));
        taken_next    = (state_next == BR) && Zero;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            instr_reg    <= '0;
            instr_ready  <= 1'b1;
            busy         <= 1'b0;
            Read1        <= '0;
            Read2        <= '0;
            WriteReg     <= '0;
            RegWrite     <= 1'b0;
            ALUOp        <= '0;
            AluSrc       <= '0;
            SEin         <= '0;
            OpCodefield  <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            done         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            if (accept) instr_reg <= instr;
            instr_ready  <= ready_next;
            busy         <= busy_next;
            Read1        <= read1_next;
            Read2        <= read2_next;
            WriteReg     <= writereg_next;
            RegWrite     <= regwrite_next;
            ALUOp        <= aluop_next;
            AluSrc       <= alusrc_next;
            SEin         <= sein_next;
            OpCodefield  <= opcode_next;
            MemRead      <= memread_next;
            MemWrite     <= memwrite_next;
            done         <= done_next;
            branch_taken <= taken_next;
            illegal      <= illegal_next;
        end
    end

endmodule

// File: tb/tb_rfaludm_sequencer.sv
// Self-checking bench for rfaludm_sequencer: directed vector table, multi-cycle corner sequences
// and randomized instructions checked against a per-cycle reference model.
module tb_rfaludm_sequencer;

    logic        clock, reset, instr_valid, instr_ready, Zero;
    logic [31:0] instr;
    logic [5:0]  Read1, Read2, WriteReg;
    logic        RegWrite, MemRead, MemWrite, busy, done, branch_taken, illegal;
    logic [1:0]  ALUOp, AluSrc;
    logic [10:0] OpCodefield;
    logic [8:0]  SEin;

    rfaludm_sequencer dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .Zero(Zero), .Read1(Read1), .Read2(Read2),
        .WriteReg(WriteReg), .RegWrite(RegWrite), .ALUOp(ALUOp), .OpCodefield(OpCodefield),
        .AluSrc(AluSrc), .SEin(SEin), .MemRead(MemRead), .MemWrite(MemWrite), .busy(busy),
        .done(done), .branch_taken(branch_taken), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef RFALUDM_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] w;
        logic        z;
        int          lat;
        logic        rw;
        logic [5:0]  wreg;
        logic        mr, mw, tk, ill;
    } vec_t;

    typedef struct {
        int         lat;
        logic       rw;
        logic [5:0] wreg;
        logic       mr, mw, tk, ill;
    } obs_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction classes: 0 R-type, 1 LDUR, 2 STUR, 3 CBZ, 4 illegal.
    function automatic int cls_of(input logic [31:0] w);
        if (w[31:24] == 8'hB4) return 3;
        case (w[31:21])
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return 0;
            11'b11111000010: return 1;
            11'b11111000000: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int lat_of(input int c);
        case (c)
            0: return 3;
            1: return 4;
            2: return 3;
            3: return 3;
            default: return 1;
        endcase
    endfunction

    // Phase of cycle k after accept: 1 decode, 2 execute, 3 memory, 4 write-back, 5 branch, 0 idle.
    function automatic int phase_of(input int c, input int k);
        if (k == 1) return 1;
        if (c == 4) return 0;
        if (k == 2) return 2;
        case (c)
            0: return (k == 3) ? 4 : 0;
            1: return (k == 3) ? 3 : (k == 4) ? 4 : 0;
            2: return (k == 3) ? 3 : 0;
            default: return (k == 3) ? 5 : 0;
        endcase
    endfunction

    task automatic run_instr(input logic [31:0] w, input logic z, output obs_t o);
        int c, lat, ph, guard;
        logic [5:0] rn, rm, rt;
        c   = cls_of(w);
        lat = lat_of(c);
        rn  = {1'b0, w[9:5]};
        rm  = {1'b0, w[20:16]};
        rt  = {1'b0, w[4:0]};
        o   = '{0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        guard = 0;
        @(negedge clock);
        while (!instr_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("ready_wait", instr_ready, 1);
        instr = w; instr_valid = 1'b1; Zero = z;
        @(posedge clock);
        #1 instr_valid = 1'b0; instr = $urandom;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clock);
            ph = phase_of(c, k);
            chk("busy", busy, k <= lat);
            chk("instr_ready", instr_ready, k > lat);
            chk("illegal", illegal, c == 4 && k == 1);
            chk("done", done, c != 4 && k == lat);
            chk("RegWrite", RegWrite, ph == 4 && !(XZR && rt == 6'd31));
            chk("MemRead", MemRead, ph == 3 && c == 1);
            chk("MemWrite", MemWrite, ph == 3 && c == 2);
            if (ph == 4) chk("WriteReg", WriteReg, rt);
            if (ph == 5) chk("branch_taken", branch_taken, z);
            if (c != 4 && ph >= 1 && ph <= 4) chk("OpCodefield", OpCodefield, w[31:21]);
            if (c != 4 && (ph == 1 || ph == 2)) begin
                chk("Read1", Read1, (c == 3) ? 6'd0 : rn);
                chk("Read2", Read2, (c == 0) ? rm : rt);
            end
            if (ph == 2) begin
                chk("ALUOp", ALUOp, (c == 0) ? 2'b10 : (c == 3) ? 2'b01 : 2'b00);
                chk("AluSrc", AluSrc, (c == 1 || c == 2) ? 2'b01 : 2'b00);
                if (c == 1 || c == 2) chk("SEin", SEin, w[20:12]);
            end
            if ((done || illegal) && o.lat == 0) o.lat = k;
            if (RegWrite) begin o.rw = 1'b1; o.wreg = WriteReg; end
            if (MemRead) o.mr = 1'b1;
            if (MemWrite) o.mw = 1'b1;
            if (done) o.tk = branch_taken;
            if (illegal) o.ill = 1'b1;
        end
        $display("instr 0x%08h zero %0d -> lat %0d rw %0d wreg %0d mr %0d mw %0d tk %0d ill %0d",
                 w, z, o.lat, o.rw, o.wreg, o.mr, o.mw, o.tk, o.ill);
    endtask

    vec_t tbl[10];
    obs_t ob;

    initial begin
        logic [31:0] w;
        logic [10:0] rops[4];
        int c, guard;
        logic seen_mw, seen_done;

        rops[0] = 11'b10001011000; rops[1] = 11'b11001011000;
        rops[2] = 11'b10001010000; rops[3] = 11'b10101010000;

        tbl[0] = '{32'h8B020023, 1'b0, 3, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{32'hF85FC045, 1'b0, 4, 1'b1, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{{11'b11111000000, 9'd8, 2'b00, 5'd2, 5'd5}, 1'b0, 3, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{{8'hB4, 19'd3, 5'd7}, 1'b1, 3, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{{8'hB4, 19'd3, 5'd7}, 1'b0, 3, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{32'h00000000, 1'b0, 1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{{11'b11001011000, 5'd6, 6'd0, 5'd5, 5'd4}, 1'b0, 3, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{{11'b10001010000, 5'd9, 6'd0, 5'd8, 5'd10}, 1'b1, 3, 1'b1, 6'd10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{{11'b10101010000, 5'd30, 6'd0, 5'd0, 5'd17}, 1'b0, 3, 1'b1, 6'd17, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{32'h8B02003F, 1'b0, 3, !XZR, XZR ? 6'd0 : 6'd31, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; instr = '0; instr_valid = 1'b0; Zero = 1'b0;
        #2;
        chk("rst_outputs", {Read1, Read2, WriteReg, RegWrite, ALUOp, OpCodefield, AluSrc, SEin,
                            MemRead, MemWrite, busy, done, branch_taken, illegal}, 0);
        chk("rst_ready", instr_ready, 1);
        #20;
        chk("rst_busy_held", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_instr(tbl[i].w, tbl[i].z, ob);
            chk("tbl_lat", ob.lat, tbl[i].lat);
            chk("tbl_rw", ob.rw, tbl[i].rw);
            chk("tbl_wreg", ob.wreg, tbl[i].wreg);
            chk("tbl_mr", ob.mr, tbl[i].mr);
            chk("tbl_mw", ob.mw, tbl[i].mw);
            chk("tbl_tk", ob.tk, tbl[i].tk);
            chk("tbl_ill", ob.ill, tbl[i].ill);
        end

        // Valid held high across an instruction: no early accept, re-accept after IDLE.
        @(negedge clock);
        instr = 32'h8B020023; instr_valid = 1'b1; Zero = 1'b0;
        @(posedge clock);
        #1 instr = {11'b11001011000, 5'd12, 6'd0, 5'd11, 5'd9};
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k == 3) begin
                chk("b2b_done", done, 1);
                chk("b2b_wreg", WriteReg, 3);
                chk("b2b_ready_at_done", instr_ready, 0);
            end
            if (k == 4) begin
                chk("b2b_idle_ready", instr_ready, 1);
                chk("b2b_idle_busy", busy, 0);
            end
            if (k == 5) begin
                chk("b2b_reaccept_busy", busy, 1);
                chk("b2b_reaccept_read1", Read1, 11);
            end
        end
        instr_valid = 1'b0;
        guard = 0;
        while (!instr_ready && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        chk("b2b_drain", instr_ready, 1);

        // Reset during EXEC of a STUR aborts it without a memory write or done.
        @(negedge clock);
        instr = {11'b11111000000, 9'd16, 2'b00, 5'd3, 5'd4}; instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("abort_in_exec", ALUOp == 2'b00 && AluSrc == 2'b01 && busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_outputs", {Read1, Read2, WriteReg, RegWrite, ALUOp, OpCodefield, AluSrc, SEin,
                              MemRead, MemWrite, busy, done, branch_taken, illegal}, 0);
        chk("abort_ready", instr_ready, 1);
        @(negedge clock);
        reset = 1'b0;
        seen_mw = 1'b0; seen_done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (MemWrite) seen_mw = 1'b1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_memwrite", seen_mw, 0);
        chk("abort_no_done", seen_done, 0);

        for (int i = 0; i < 40; i++) begin
            c = $urandom_range(0, 4);
            case (c)
                0: w = {rops[$urandom_range(0, 3)], 5'($urandom), 6'($urandom), 5'($urandom), 5'($urandom)};
                1: w = {11'b11111000010, 9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
                2: w = {11'b11111000000, 9'($urandom), 2'b00, 5'($urandom), 5'($urandom)};
                3: w = {8'hB4, 19'($urandom), 5'($urandom)};
                default: begin
                    w = 32'h0;
                    for (int t = 0; t < 8; t++) begin
                        w = $urandom;
                        if (cls_of(w) == 4) break;
                        w = 32'h0;
                    end
                end
            endcase
            run_instr(w, 1'($urandom), ob);
            chk("rnd_lat", ob.lat, lat_of(c));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
